// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the shift-add multiplier slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

  localparam int WIDTH  = 4;
  localparam int CNT_W  = 2;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle between a requester and the shift-add multiplier.
// Latency: none (wiring only).
// Backpressure: a requester must watch busy; start is ignored while busy is high.
interface shift_add_multiplier_if;

  logic                           start;
  logic [alu_pkg::WIDTH-1:0]      A;
  logic [alu_pkg::WIDTH-1:0]      B;
  logic [alu_pkg::PROD_W-1:0]     P;
  logic                           busy;
  logic                           done;

  modport master (output start, A, B, input P, busy, done);
  modport slave  (input start, A, B, output P, busy, done);

endinterface

// File: rtl/cla_adder_subtractor.sv
// 4-bit carry-lookahead adder/subtractor: S = A + (B ^ {4{M}}) + M.
// Latency: purely combinational.
// Backpressure: none.
module cla_adder_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] bx;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // generate/propagate terms and flattened lookahead carries
  always_comb begin
    bx   = B ^ {4{M}};
    g    = A & bx;
    p    = A ^ bx;
    c[0] = M;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    Cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    S    = p ^ c;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 4x4 shift-add multiplier using a single CLA adder.
// Latency: done is high in the cycle after the 8th edge following the accepting edge; IDLE again one edge later.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module shift_add_multiplier #(
  parameter int WIDTH = alu_pkg::WIDTH  // only 4 is supported (adder is fixed-width)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shift_add_multiplier_if.slave  bus
);

  alu_pkg::state_t               state;
  alu_pkg::state_t               state_nxt;
  logic [WIDTH-1:0]              mcand;
  logic [WIDTH:0]                acc;    // acc[WIDTH] keeps the adder carry
  logic [WIDTH-1:0]              q;
  logic [alu_pkg::CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]            p_reg;
  logic [WIDTH-1:0]              sum;
  logic                          cout;

  cla_adder_subtractor u_adder (
    .A    (acc[WIDTH-1:0]),
    .B    (mcand),
    .M    (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // next-state decode: ADD/SHIFT alternate four times, then a single DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      alu_pkg::IDLE:  if (bus.start) state_nxt = alu_pkg::ADD;
      alu_pkg::ADD:   state_nxt = alu_pkg::SHIFT;
      alu_pkg::SHIFT: state_nxt = (cnt == '1) ? alu_pkg::DONE : alu_pkg::ADD;
      alu_pkg::DONE:  state_nxt = alu_pkg::IDLE;
      default:        state_nxt = alu_pkg::IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any operation and clears the product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= alu_pkg::IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      p_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        alu_pkg::IDLE: begin
          if (bus.start) begin
            mcand <= bus.A;
            q     <= bus.B;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        alu_pkg::ADD: begin
          if (q[0]) acc <= {cout, sum};
          else      acc <= {1'b0, acc[WIDTH-1:0]};
        end
        alu_pkg::SHIFT: begin
          {acc, q} <= {1'b0, acc, q[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
          // product is the post-shift {acc[3:0], q}, i.e. the pre-shift {acc, q[3:1]}
          if (cnt == '1) p_reg <= {acc, q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only
  always_comb begin
    bus.busy = (state != alu_pkg::IDLE);
    bus.done = (state == alu_pkg::DONE);
    bus.P    = p_reg;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier against a plain a*b reference.
// Latency: expects done 8 edges after the accepting edge and 9 busy cycles.
// Backpressure: exercises start held high and operand churn while busy.
module tb_shift_add_multiplier;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  shift_add_multiplier_if bus ();

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request from an idle DUT and observe it to completion.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold,
                        output logic [7:0] p, output int lat, output int busy_cyc,
                        output int dones, output int hold_bad, output bit timeout);
    logic [7:0] prev;
    @(negedge clk);
    prev      = bus.P;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    bus.A = 4'($urandom);
    bus.B = 4'($urandom);
    p = 8'h00; lat = -1; busy_cyc = 0; dones = 0; hold_bad = 0; timeout = 1'b1;
    for (int e = 0; e < 30; e++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        dones++;
        lat = e;
        p   = bus.P;
      end else if (dones == 0 && bus.P !== prev) begin
        hold_bad++;
      end
      if (!bus.busy && dones > 0) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      if (hold) begin
        bus.A = 4'($urandom);
        bus.B = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.A     = 4'd0;
    bus.B     = 4'd0;
    rst_n     = 1'b0;
    #12;
    checks++; if (bus.P !== 8'h00) begin errors++; $display("FAIL reset_p: got %0h expected 0", bus.P); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] p; int lat, bc, dn, hb; bit to;
    run_op(4'd3, 4'd1, 1'b0, p, lat, bc, dn, hb, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: no completion within budget"); end
    checks++; if (p !== 8'h03) begin errors++; $display("FAIL basic_p: got %0h expected 03", p); end
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    checks++; if (bc != 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 9", bc); end
    checks++; if (dn != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
    checks++; if (hb != 0) begin errors++; $display("FAIL basic_p_hold: got %0d changes expected 0", hb); end
  endtask

  task automatic test_carry();
    logic [7:0] p; int lat, bc, dn, hb; bit to;
    run_op(4'd15, 4'd15, 1'b0, p, lat, bc, dn, hb, to);
    checks++; if (p !== 8'hE1) begin errors++; $display("FAIL carry_p: got %0h expected e1", p); end
    checks++; if (dn != 1) begin errors++; $display("FAIL carry_done_count: got %0d expected 1", dn); end
    checks++; if (hb != 0) begin errors++; $display("FAIL carry_p_hold: got %0d changes expected 0", hb); end
  endtask

  task automatic test_zero();
    logic [7:0] p; int lat, bc, dn, hb; bit to;
    run_op(4'd9, 4'd6, 1'b0, p, lat, bc, dn, hb, to);
    checks++; if (p !== 8'h36) begin errors++; $display("FAIL zero_pre_p: got %0h expected 36", p); end
    run_op(4'd0, 4'd13, 1'b0, p, lat, bc, dn, hb, to);
    checks++; if (p !== 8'h00) begin errors++; $display("FAIL zero_a_p: got %0h expected 00", p); end
    checks++; if (lat != 8) begin errors++; $display("FAIL zero_a_latency: got %0d expected 8", lat); end
    checks++; if (bc != 9) begin errors++; $display("FAIL zero_a_busy_cycles: got %0d expected 9", bc); end
    run_op(4'd13, 4'd0, 1'b0, p, lat, bc, dn, hb, to);
    checks++; if (p !== 8'h00) begin errors++; $display("FAIL zero_b_p: got %0h expected 00", p); end
    checks++; if (lat != 8) begin errors++; $display("FAIL zero_b_latency: got %0d expected 8", lat); end
  endtask

  task automatic test_held_start();
    logic [7:0] p; int lat, bc, dn, hb; bit to; bit found;
    run_op(4'd5, 4'd3, 1'b1, p, lat, bc, dn, hb, to);
    checks++; if (p !== 8'h0F) begin errors++; $display("FAIL held_p: got %0h expected 0f", p); end
    checks++; if (bc != 9) begin errors++; $display("FAIL held_busy_cycles: got %0d expected 9", bc); end
    checks++; if (dn != 1) begin errors++; $display("FAIL held_done_count: got %0d expected 1", dn); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_idle_gap: got busy=%b expected 0", bus.busy); end
    // start is still high: the DUT should accept again only now, from IDLE
    bus.A = 4'd5;
    bus.B = 4'd3;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL held_reaccept: got busy=%b expected 1", bus.busy); end
    bus.start = 1'b0;
    bus.A = 4'd14;
    bus.B = 4'd11;
    found = 1'b0;
    p = 8'h00;
    for (int e = 0; e < 30; e++) begin
      if (bus.done) begin
        found = 1'b1;
        p = bus.P;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL held_second_done: got none expected 1"); end
    checks++; if (p !== 8'h0F) begin errors++; $display("FAIL held_second_p: got %0h expected 0f", p); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] p; int lat, bc, dn, hb; bit to; int done_seen;
    @(negedge clk);
    bus.A = 4'd7;
    bus.B = 4'd7;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.P !== 8'h00) begin errors++; $display("FAIL rstmid_p: got %0h expected 00", bus.P); end
    done_seen = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (e == 2) rst_n = 1'b1;
      if (bus.done) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_seen); end
    checks++; if (bus.P !== 8'h00) begin errors++; $display("FAIL rstmid_p_after: got %0h expected 00", bus.P); end
    run_op(4'd7, 4'd7, 1'b0, p, lat, bc, dn, hb, to);
    checks++; if (p !== 8'h31) begin errors++; $display("FAIL rstmid_rerun_p: got %0h expected 31", p); end
    checks++; if (lat != 8) begin errors++; $display("FAIL rstmid_rerun_latency: got %0d expected 8", lat); end
  endtask

  task automatic test_random();
    logic [7:0] p, exp_p; logic [3:0] a, b; int lat, bc, dn, hb; bit to;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      exp_p = {4'b0, a} * {4'b0, b};
      run_op(a, b, 1'b0, p, lat, bc, dn, hb, to);
      checks++; if (p !== exp_p) begin errors++; $display("FAIL random_p %0d*%0d: got %0h expected %0h", a, b, p, exp_p); end
      checks++; if (lat != 8) begin errors++; $display("FAIL random_latency %0d*%0d: got %0d expected 8", a, b, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p, exp_p; int lat, bc, dn, hb; bit to;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_p = 8'(a * b);
        run_op(4'(a), 4'(b), 1'b0, p, lat, bc, dn, hb, to);
        checks++; if (p !== exp_p) begin errors++; $display("FAIL sweep_p %0d*%0d: got %0h expected %0h", a, b, p, exp_p); end
        checks++; if (dn != 1) begin errors++; $display("FAIL sweep_done_count %0d*%0d: got %0d expected 1", a, b, dn); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_held_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
